// File: rtl/qgate_pipe.sv
// qgate_pipe: two-stage pipelined single-qubit gate engine (I, X, Y, Z, H, S, SDG)
// on a signed fixed-point amplitude pair, with valid/ready on both sides.
// Optional completed-output counter enabled by defining QGATE_PERF_CNT_EN.
module qgate_pipe #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_W    = 8,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned INV_SQRT2 = 181
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] alpha_re,
  input  logic [DATA_W-1:0] alpha_im,
  input  logic [DATA_W-1:0] beta_re,
  input  logic [DATA_W-1:0] beta_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_alpha_re,
  output logic [DATA_W-1:0] out_alpha_im,
  output logic [DATA_W-1:0] out_beta_re,
  output logic [DATA_W-1:0] out_beta_im,
  output logic              op_err,
  output logic [31:0]       gate_cnt
);

  localparam int unsigned SUM_W  = DATA_W + 1;
  localparam int unsigned PROD_W = SUM_W + DATA_W;

  localparam logic [2:0] OP_X   = 3'd1;
  localparam logic [2:0] OP_Y   = 3'd2;
  localparam logic [2:0] OP_Z   = 3'd3;
  localparam logic [2:0] OP_H   = 3'd4;
  localparam logic [2:0] OP_S   = 3'd5;
  localparam logic [2:0] OP_SDG = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] P_MAX = PROD_W'(S_MAX);
  localparam logic signed [PROD_W-1:0] P_MIN = PROD_W'(S_MIN);
  localparam logic signed [PROD_W-1:0] P_K   = PROD_W'(INV_SQRT2);
  localparam logic signed [PROD_W-1:0] P_RND = PROD_W'(2 ** (FRAC_W - 1));

  // Saturating negation: the most negative value maps to the most positive.
  function automatic logic signed [DATA_W-1:0] sat_neg(input logic signed [DATA_W-1:0] x);
    sat_neg = (x == S_MIN) ? S_MAX : -x;
  endfunction

  // Sign-extend a component into the S1 storage width.
  function automatic logic signed [SUM_W-1:0] ext(input logic signed [DATA_W-1:0] x);
    ext = SUM_W'(x);
  endfunction

  // Hadamard scaling: multiply by 1/sqrt(2), round half up, shift, saturate.
  function automatic logic signed [DATA_W-1:0] h_scale(input logic signed [SUM_W-1:0] s);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(s) * P_K;
    p = (p + P_RND) >>> FRAC_W;
    if (p > P_MAX)      h_scale = S_MAX;
    else if (p < P_MIN) h_scale = S_MIN;
    else                h_scale = DATA_W'(p);
  endfunction

  logic signed [DATA_W-1:0] ar, ai, br, bi;
  assign ar = $signed(alpha_re);
  assign ai = $signed(alpha_im);
  assign br = $signed(beta_re);
  assign bi = $signed(beta_im);

  logic                    s1_valid_q, s1_valid_d;
  logic [2:0]              s1_op_q, s1_op_d;
  logic [TAG_W-1:0]        s1_tag_q, s1_tag_d;
  logic signed [SUM_W-1:0] s1_ar_q, s1_ar_d, s1_ai_q, s1_ai_d;
  logic signed [SUM_W-1:0] s1_br_q, s1_br_d, s1_bi_q, s1_bi_d;

  logic                     out_valid_q, out_valid_d;
  logic [TAG_W-1:0]         out_tag_q, out_tag_d;
  logic signed [DATA_W-1:0] out_ar_q, out_ar_d, out_ai_q, out_ai_d;
  logic signed [DATA_W-1:0] out_br_q, out_br_d, out_bi_q, out_bi_d;
  logic                     op_err_q, op_err_d;

  logic s2_load, s1_load, accept;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid && s1_load;

  // S1 next state: swap/negate per opcode, or H sum/difference at full width.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s1_ar_d    = s1_ar_q;
    s1_ai_d    = s1_ai_q;
    s1_br_d    = s1_br_q;
    s1_bi_d    = s1_bi_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      s1_op_d    = in_op;
      s1_tag_d   = in_tag;
      s1_ar_d    = ext(ar);
      s1_ai_d    = ext(ai);
      s1_br_d    = ext(br);
      s1_bi_d    = ext(bi);
      case (in_op)
        OP_X: begin
          s1_ar_d = ext(br);
          s1_ai_d = ext(bi);
          s1_br_d = ext(ar);
          s1_bi_d = ext(ai);
        end
        OP_Y: begin
          s1_ar_d = ext(bi);
          s1_ai_d = ext(sat_neg(br));
          s1_br_d = ext(sat_neg(ai));
          s1_bi_d = ext(ar);
        end
        OP_Z: begin
          s1_br_d = ext(sat_neg(br));
          s1_bi_d = ext(sat_neg(bi));
        end
        OP_H: begin
          s1_ar_d = ext(ar) + ext(br);
          s1_ai_d = ext(ai) + ext(bi);
          s1_br_d = ext(ar) - ext(br);
          s1_bi_d = ext(ai) - ext(bi);
        end
        OP_S: begin
          s1_br_d = ext(sat_neg(bi));
          s1_bi_d = ext(br);
        end
        OP_SDG: begin
          s1_br_d = ext(bi);
          s1_bi_d = ext(sat_neg(br));
        end
        default: ;
      endcase
    end
  end

  // S2 next state: H scaling or pass-through; sticky reserved-opcode flag.
  always_comb begin
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_ar_d    = out_ar_q;
    out_ai_d    = out_ai_q;
    out_br_d    = out_br_q;
    out_bi_d    = out_bi_q;
    op_err_d    = op_err_q || (accept && (in_op == OP_RSV));
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_tag_d = s1_tag_q;
        if (s1_op_q == OP_H) begin
          out_ar_d = h_scale(s1_ar_q);
          out_ai_d = h_scale(s1_ai_q);
          out_br_d = h_scale(s1_br_q);
          out_bi_d = h_scale(s1_bi_q);
        end else begin
          out_ar_d = DATA_W'(s1_ar_q);
          out_ai_d = DATA_W'(s1_ai_q);
          out_br_d = DATA_W'(s1_br_q);
          out_bi_d = DATA_W'(s1_bi_q);
        end
      end
    end
  end

  // Pipeline registers for both stages and the error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_tag_q    <= '0;
      s1_ar_q     <= '0;
      s1_ai_q     <= '0;
      s1_br_q     <= '0;
      s1_bi_q     <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_ar_q    <= '0;
      out_ai_q    <= '0;
      out_br_q    <= '0;
      out_bi_q    <= '0;
      op_err_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_tag_q    <= s1_tag_d;
      s1_ar_q     <= s1_ar_d;
      s1_ai_q     <= s1_ai_d;
      s1_br_q     <= s1_br_d;
      s1_bi_q     <= s1_bi_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_ar_q    <= out_ar_d;
      out_ai_q    <= out_ai_d;
      out_br_q    <= out_br_d;
      out_bi_q    <= out_bi_d;
      op_err_q    <= op_err_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_tag      = out_tag_q;
  assign out_alpha_re = out_ar_q;
  assign out_alpha_im = out_ai_q;
  assign out_beta_re  = out_br_q;
  assign out_beta_im  = out_bi_q;
  assign op_err       = op_err_q;

`ifdef QGATE_PERF_CNT_EN
  logic [31:0] gate_cnt_q;

  // Count consumed outputs, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         gate_cnt_q <= 32'd0;
    else if (out_valid_q && out_ready)  gate_cnt_q <= gate_cnt_q + 32'd1;
  end

  assign gate_cnt = gate_cnt_q;
`else
  assign gate_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_qgate_pipe.sv
// Directed + random bench for qgate_pipe with an in-order scoreboard.
module tb_qgate_pipe;

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] ar;
    logic [15:0] ai;
    logic [15:0] br;
    logic [15:0] bi;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic [15:0] alpha_re, alpha_im, beta_re, beta_im;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_tag;
  logic [15:0] out_alpha_re, out_alpha_im, out_beta_re, out_beta_im;
  logic        op_err;
  logic [31:0] gate_cnt;

  logic rdy_man, rnd_rdy, rand_mode;
  assign out_ready = rand_mode ? rnd_rdy : rdy_man;

  int tests = 0;
  int fails = 0;
  int out_count = 0;
  sb_t sb_q[$];

  qgate_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
    .alpha_re(alpha_re), .alpha_im(alpha_im), .beta_re(beta_re), .beta_im(beta_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_alpha_re(out_alpha_re), .out_alpha_im(out_alpha_im),
    .out_beta_re(out_beta_re), .out_beta_im(out_beta_im),
    .op_err(op_err), .gate_cnt(gate_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] nneg(input logic [15:0] x);
    int v;
    v = -int'($signed(x));
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  function automatic logic [15:0] hs(input int s);
    longint p;
    p = (longint'(s) * 181 + 128) >>> 8;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  function automatic sb_t model(input logic [2:0] op, input logic [3:0] tag,
                                input logic [15:0] ar, ai, br, bi);
    sb_t r;
    r = '{tag: tag, ar: ar, ai: ai, br: br, bi: bi};
    case (op)
      3'd1: begin r.ar = br; r.ai = bi; r.br = ar; r.bi = ai; end
      3'd2: begin r.ar = bi; r.ai = nneg(br); r.br = nneg(ai); r.bi = ar; end
      3'd3: begin r.br = nneg(br); r.bi = nneg(bi); end
      3'd4: begin
        r.ar = hs(int'($signed(ar)) + int'($signed(br)));
        r.ai = hs(int'($signed(ai)) + int'($signed(bi)));
        r.br = hs(int'($signed(ar)) - int'($signed(br)));
        r.bi = hs(int'($signed(ai)) - int'($signed(bi)));
      end
      3'd5: begin r.br = nneg(bi); r.bi = br; end
      3'd6: begin r.br = bi; r.bi = nneg(br); end
      default: ;
    endcase
    return r;
  endfunction

  // Scoreboard: compare each consumed output against the oldest expectation.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      chk("gate_cnt_run", 80'(gate_cnt),
`ifdef QGATE_PERF_CNT_EN
          80'(out_count)
`else
          80'd0
`endif
      );
      if (sb_q.size() == 0) begin
        chk("unexpected_out", 80'(out_valid), 80'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_data", 80'({out_tag, out_alpha_re, out_alpha_im, out_beta_re, out_beta_im}), 80'(e));
      end
      out_count++;
    end
  end

  // Drive one transaction (called at posedge+1) and push its expectation on accept.
  task automatic send_exp(input logic [2:0] op, input logic [3:0] tag,
                          input logic [15:0] ar, ai, br, bi, input sb_t exp);
    bit done = 0;
    in_valid = 1'b1; in_op = op; in_tag = tag;
    alpha_re = ar; alpha_im = ai; beta_re = br; beta_im = bi;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(exp);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 80'd0, 80'd1);
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] tag,
                      input logic [15:0] ar, ai, br, bi);
    send_exp(op, tag, ar, ai, br, bi, model(op, tag, ar, ai, br, bi));
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 80'(sb_q.size()), 80'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    sb_q.delete();
    out_count = 0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  logic [15:0] snap_ar;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_op = '0; in_tag = '0;
    alpha_re = '0; alpha_im = '0; beta_re = '0; beta_im = '0;
    rdy_man = 1'b1; rand_mode = 1'b0;
    #1;
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_out_data", 80'({out_tag, out_alpha_re, out_alpha_im, out_beta_re, out_beta_im}), 80'd0);
    chk("rst_op_err", 80'(op_err), 80'd0);
    chk("rst_gate_cnt", 80'(gate_cnt), 80'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 80'(in_ready), 80'd1);
    @(posedge clk); #1;

    // X on |0> with latency check
    send_exp(3'd1, 4'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
             '{tag: 4'd1, ar: 16'h0000, ai: 16'h0000, br: 16'h0100, bi: 16'h0000});
    @(negedge clk);
    chk("lat_cycle1", 80'(out_valid), 80'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_cycle2", 80'(out_valid), 80'd1);
    @(posedge clk); #1;
    drain();

    // H on |0> and H saturation
    send_exp(3'd4, 4'd2, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
             '{tag: 4'd2, ar: 16'h00B5, ai: 16'h0000, br: 16'h00B5, bi: 16'h0000});
    send_exp(3'd4, 4'd3, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000,
             '{tag: 4'd3, ar: 16'h7FFF, ai: 16'h0000, br: 16'h0000, bi: 16'h0000});
    // Y on complex input
    send_exp(3'd2, 4'd4, 16'h0080, 16'hFF80, 16'h0040, 16'h00C0,
             '{tag: 4'd4, ar: 16'h00C0, ai: 16'hFFC0, br: 16'h0080, bi: 16'h0080});
    // Z with saturating negation
    send_exp(3'd3, 4'd5, 16'h0100, 16'h0020, 16'h8000, 16'h0010,
             '{tag: 4'd5, ar: 16'h0100, ai: 16'h0020, br: 16'h7FFF, bi: 16'hFFF0});
    // S and SDG
    send_exp(3'd5, 4'd6, 16'h0011, 16'h0022, 16'h0033, 16'h8000,
             '{tag: 4'd6, ar: 16'h0011, ai: 16'h0022, br: 16'h7FFF, bi: 16'h0033});
    send_exp(3'd6, 4'd7, 16'h0011, 16'h0022, 16'h0033, 16'h0044,
             '{tag: 4'd7, ar: 16'h0011, ai: 16'h0022, br: 16'h0044, bi: 16'hFFCD});
    // Identity
    send_exp(3'd0, 4'd8, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
             '{tag: 4'd8, ar: 16'h1234, ai: 16'h5678, br: 16'h9ABC, bi: 16'hDEF0});
    drain();

    // Backpressure from a fresh reset
    do_reset();
    rdy_man = 1'b0;
    send(3'd1, 4'd1, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    send(3'd2, 4'd2, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
    @(negedge clk);
    snap_ar = out_alpha_re;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 80'(in_ready), 80'd0);
      chk("bp_out_valid", 80'(out_valid), 80'd1);
      chk("bp_tag_hold", 80'(out_tag), 80'd1);
      chk("bp_data_hold", 80'(out_alpha_re), 80'(snap_ar));
      @(negedge clk);
    end
    @(posedge clk); #1;
    rdy_man = 1'b1;
    send(3'd3, 4'd3, 16'h0009, 16'h000A, 16'h000B, 16'h000C);
    send(3'd4, 4'd4, 16'h0100, 16'h0080, 16'hFF00, 16'h0040);
    drain();
`ifdef QGATE_PERF_CNT_EN
    chk("bp_gate_cnt", 80'(gate_cnt), 80'd4);
`else
    chk("bp_gate_cnt", 80'(gate_cnt), 80'd0);
`endif

    // Reserved opcode behaves as identity and sets the sticky flag
    chk("op_err_clear", 80'(op_err), 80'd0);
    send_exp(3'd7, 4'd9, 16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0,
             '{tag: 4'd9, ar: 16'hAAAA, ai: 16'h5555, br: 16'h0F0F, bi: 16'hF0F0});
    drain();
    chk("op_err_set", 80'(op_err), 80'd1);
    send(3'd0, 4'd10, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    drain();
    chk("op_err_sticky", 80'(op_err), 80'd1);

    // Random ops under random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, 6)), 4'(i), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom));
    end
    drain();
    rand_mode = 1'b0;
    rdy_man = 1'b1;

    // Reset with transactions in flight
    rdy_man = 1'b0;
    send(3'd1, 4'd11, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
    send(3'd7, 4'd12, 16'h0200, 16'h0000, 16'h0000, 16'h0000);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 80'(out_valid), 80'd0);
    chk("mid_rst_op_err", 80'(op_err), 80'd0);
    chk("mid_rst_data", 80'({out_tag, out_alpha_re, out_alpha_im, out_beta_re, out_beta_im}), 80'd0);
    chk("mid_rst_cnt", 80'(gate_cnt), 80'd0);
    sb_q.delete();
    out_count = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    rdy_man = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 80'(out_valid), 80'd0);
      chk("post_rst_in_ready", 80'(in_ready), 80'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
